// File: rtl/ad_mux_adc_rx_if.sv
// Signal bundle between the muxed ADC input registers, the A/B demux and the
// processing chain. fsm_state_o exposes the demux FSM for observation.
interface ad_mux_adc_rx_if #(
   parameter int DATA_WIDTH = 14
);
   logic [DATA_WIDTH-1:0] adc_dat_i;
   logic                  adc_sel_i;
   logic                  adc_ovr_i;
   logic                  enable_i;
   logic                  ovr_clr_i;
   logic [DATA_WIDTH-1:0] data_a_o;
   logic                  data_a_en_o;
   logic [DATA_WIDTH-1:0] data_b_o;
   logic                  data_b_en_o;
   logic                  ovr_a_o;
   logic                  ovr_b_o;
   logic                  locked_o;
   logic                  sync_err_o;
   logic [15:0]           sync_err_cnt_o;
   logic [1:0]            fsm_state_o;

   // Stream convention: data_x_o is valid only in the cycle its data_x_en_o is
   // high. There is no backpressure; the consumer must accept every strobe.
   modport slave (
      input  adc_dat_i, adc_sel_i, adc_ovr_i, enable_i, ovr_clr_i,
      output data_a_o, data_a_en_o, data_b_o, data_b_en_o,
      output ovr_a_o, ovr_b_o, locked_o, sync_err_o, sync_err_cnt_o, fsm_state_o
   );

   modport master (
      output adc_dat_i, adc_sel_i, adc_ovr_i, enable_i, ovr_clr_i,
      input  data_a_o, data_a_en_o, data_b_o, data_b_en_o,
      input  ovr_a_o, ovr_b_o, locked_o, sync_err_o, sync_err_cnt_o, fsm_state_o
   );
endinterface

// File: rtl/ad_mux_adc_rx.sv
// Dual-channel muxed ADC receiver: demuxes A/B samples into aligned pairs,
// converts inverted offset-binary to two's complement, tracks lock and overrange.
module ad_mux_adc_rx #(
   parameter int DATA_WIDTH = 14,
   parameter int LOCK_PAIRS = 4
) (
   input  logic            adc_clk_i,
   input  logic            adc_rst_i,
   ad_mux_adc_rx_if.slave  bus
);
   localparam logic [7:0] LOCK_MAX = 8'(LOCK_PAIRS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HUNT  = 2'd1,
      S_GOT_A = 2'd2,
      S_EXP_A = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] s1_dat;
   logic                  s1_sel, s1_ovr;
   logic [DATA_WIDTH-1:0] held_a_q, held_a_d;
   logic                  held_ovr_q, held_ovr_d;
   logic                  emit, err, lock_clr;
   logic [DATA_WIDTH-1:0] conv;

   logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
   logic                  data_en_q;
   logic                  ovr_a_q, ovr_b_q;
   logic [7:0]            good_cnt_q;
   logic                  sync_err_q;
   logic [15:0]           err_cnt_q;

   // Offset-binary with inverted LSBs: keep the MSB, invert everything below.
   assign conv = {s1_dat[DATA_WIDTH-1], ~s1_dat[DATA_WIDTH-2:0]};

   always_comb begin
      state_d    = state_q;
      held_a_d   = held_a_q;
      held_ovr_d = held_ovr_q;
      emit       = 1'b0;
      err        = 1'b0;
      if (!bus.enable_i) begin
         state_d    = S_IDLE;
         held_a_d   = '0;
         held_ovr_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_HUNT;
            S_HUNT: begin
               if (s1_sel) begin
                  held_a_d   = conv;
                  held_ovr_d = s1_ovr;
                  state_d    = S_GOT_A;
               end
            end
            S_GOT_A: begin
               if (s1_sel) begin
                  // Repeated A: newest A replaces the held one.
                  err        = 1'b1;
                  held_a_d   = conv;
                  held_ovr_d = s1_ovr;
               end else begin
                  emit    = 1'b1;
                  state_d = S_EXP_A;
               end
            end
            S_EXP_A: begin
               if (s1_sel) begin
                  held_a_d   = conv;
                  held_ovr_d = s1_ovr;
                  state_d    = S_GOT_A;
               end else begin
                  err     = 1'b1;
                  state_d = S_HUNT;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign lock_clr = err || (state_q == S_IDLE) || (state_d == S_IDLE);

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         s1_dat     <= '0;
         s1_sel     <= 1'b0;
         s1_ovr     <= 1'b0;
         state_q    <= S_IDLE;
         held_a_q   <= '0;
         held_ovr_q <= 1'b0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         data_en_q  <= 1'b0;
         ovr_a_q    <= 1'b0;
         ovr_b_q    <= 1'b0;
         good_cnt_q <= '0;
         sync_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         s1_dat     <= bus.adc_dat_i;
         s1_sel     <= bus.adc_sel_i;
         s1_ovr     <= bus.adc_ovr_i;
         state_q    <= state_d;
         held_a_q   <= held_a_d;
         held_ovr_q <= held_ovr_d;
         data_en_q  <= emit;
         if (emit) begin
            data_a_q <= held_a_q;
            data_b_q <= conv;
         end
         // A new overrange on the emitted pair beats a coincident clear.
         ovr_a_q <= (emit && held_ovr_q) || (ovr_a_q && !bus.ovr_clr_i);
         ovr_b_q <= (emit && s1_ovr)     || (ovr_b_q && !bus.ovr_clr_i);
         if (lock_clr)
            good_cnt_q <= '0;
         else if (emit && good_cnt_q != LOCK_MAX)
            good_cnt_q <= good_cnt_q + 8'd1;
         sync_err_q <= err;
         if (err && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign bus.data_a_o       = data_a_q;
   assign bus.data_b_o       = data_b_q;
   assign bus.data_a_en_o    = data_en_q;
   assign bus.data_b_en_o    = data_en_q;
   assign bus.ovr_a_o        = ovr_a_q;
   assign bus.ovr_b_o        = ovr_b_q;
   assign bus.locked_o       = (good_cnt_q == LOCK_MAX);
   assign bus.sync_err_o     = sync_err_q;
   assign bus.sync_err_cnt_o = err_cnt_q;
   assign bus.fsm_state_o    = state_q;
endmodule

// File: tb/tb_ad_mux_adc_rx.sv
// Directed bench for ad_mux_adc_rx: lock, coding, alignment errors, overrange,
// enable drop, mid-stream reset and error-counter saturation.
module tb_ad_mux_adc_rx;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ad_mux_adc_rx_if #(.DATA_WIDTH(14)) bus ();

   ad_mux_adc_rx #(.DATA_WIDTH(14), .LOCK_PAIRS(4)) dut (
      .adc_clk_i (clk),
      .adc_rst_i (rst),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one sample, let it be captured on the next rising edge, settle.
   task automatic drive(input logic sel, input logic [13:0] dat, input logic ovr);
      bus.adc_sel_i = sel;
      bus.adc_dat_i = dat;
      bus.adc_ovr_i = ovr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.adc_sel_i = 1'b0;
      bus.adc_dat_i = '0;
      bus.adc_ovr_i = 1'b0;
      bus.enable_i  = 1'b0;
      bus.ovr_clr_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_data_a", 16'(bus.data_a_o), 16'h0000);
      chk("rst_data_b", 16'(bus.data_b_o), 16'h0000);
      chk("rst_en_a", 16'(bus.data_a_en_o), 16'h0);
      chk("rst_en_b", 16'(bus.data_b_en_o), 16'h0);
      chk("rst_locked", 16'(bus.locked_o), 16'h0);
      chk("rst_ovr_a", 16'(bus.ovr_a_o), 16'h0);
      chk("rst_ovr_b", 16'(bus.ovr_b_o), 16'h0);
      chk("rst_err", 16'(bus.sync_err_o), 16'h0);
      chk("rst_errcnt", bus.sync_err_cnt_o, 16'h0000);
      chk("rst_state", 16'(bus.fsm_state_o), 16'h0);

      // Alternating A=0x1FFF, B=0x0000; lock on the 4th pair
      rst = 1'b0;
      bus.enable_i = 1'b1;
      drive(1'b0, 14'h0000, 1'b0);
      drive(1'b1, 14'h1FFF, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 14'h0000, 1'b0);
         chk("alt_no_strobe", 16'(bus.data_a_en_o), 16'h0);
         drive(1'b1, 14'h1FFF, 1'b0);
         chk("alt_strobe_a", 16'(bus.data_a_en_o), 16'h1);
         chk("alt_strobe_b", 16'(bus.data_b_en_o), 16'h1);
         chk("alt_data_a", 16'(bus.data_a_o), 16'h0000);
         chk("alt_data_b", 16'(bus.data_b_o), 16'h1FFF);
         chk("alt_locked", 16'(bus.locked_o), (k == 4) ? 16'h1 : 16'h0);
      end
      chk("alt_errcnt", bus.sync_err_cnt_o, 16'h0000);

      // Coding sweep: A 0x3FFF -> 0x2000, B 0x2000 -> 0x3FFF
      drive(1'b0, 14'h2000, 1'b0);
      chk("code_no_strobe", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b1, 14'h3FFF, 1'b0);
      chk("code1_a", 16'(bus.data_a_o), 16'h0000);
      chk("code1_b", 16'(bus.data_b_o), 16'h3FFF);
      drive(1'b0, 14'h2000, 1'b0);
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("code2_en", 16'(bus.data_a_en_o), 16'h1);
      chk("code2_a", 16'(bus.data_a_o), 16'h2000);
      chk("code2_b", 16'(bus.data_b_o), 16'h3FFF);
      chk("code2_locked", 16'(bus.locked_o), 16'h1);

      // Sel 1,1,0 from lock: error, unlock, pair uses second A
      drive(1'b1, 14'h1000, 1'b0);
      chk("hold_data_a", 16'(bus.data_a_o), 16'h2000);
      chk("hold_en", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b0, 14'h0000, 1'b0);
      chk("aa_err", 16'(bus.sync_err_o), 16'h1);
      chk("aa_locked", 16'(bus.locked_o), 16'h0);
      chk("aa_errcnt", bus.sync_err_cnt_o, 16'h0001);
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("aa_err_pulse", 16'(bus.sync_err_o), 16'h0);
      chk("aa_en", 16'(bus.data_a_en_o), 16'h1);
      chk("aa_data_a", 16'(bus.data_a_o), 16'h0FFF);
      chk("aa_data_b", 16'(bus.data_b_o), 16'h1FFF);

      // Sel 0,0 in EXP_A: error, back to HUNT, no strobe until next A,B
      drive(1'b0, 14'h0000, 1'b0);
      drive(1'b0, 14'h0000, 1'b0);
      chk("bb_pair_en", 16'(bus.data_a_en_o), 16'h1);
      drive(1'b0, 14'h0000, 1'b0);
      chk("bb_err", 16'(bus.sync_err_o), 16'h1);
      chk("bb_errcnt", bus.sync_err_cnt_o, 16'h0002);
      chk("bb_no_strobe", 16'(bus.data_a_en_o), 16'h0);
      chk("bb_state_hunt", 16'(bus.fsm_state_o), 16'h1);
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("bb_hunt_no_err", 16'(bus.sync_err_o), 16'h0);
      chk("bb_hunt_no_strobe", 16'(bus.data_a_en_o), 16'h0);

      // Overrange on B, sticky, clear, clear coincident with new set
      drive(1'b0, 14'h0000, 1'b1);
      chk("ovr_pre_en", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("ovr_en", 16'(bus.data_a_en_o), 16'h1);
      chk("ovr_b_set", 16'(bus.ovr_b_o), 16'h1);
      chk("ovr_a_clear", 16'(bus.ovr_a_o), 16'h0);
      drive(1'b0, 14'h0000, 1'b0);
      chk("ovr_b_sticky", 16'(bus.ovr_b_o), 16'h1);
      bus.ovr_clr_i = 1'b1;
      drive(1'b1, 14'h1FFF, 1'b0);
      bus.ovr_clr_i = 1'b0;
      chk("ovr_b_cleared", 16'(bus.ovr_b_o), 16'h0);
      drive(1'b0, 14'h0000, 1'b1);
      bus.ovr_clr_i = 1'b1;
      drive(1'b1, 14'h1FFF, 1'b0);
      bus.ovr_clr_i = 1'b0;
      chk("ovr_set_wins", 16'(bus.ovr_b_o), 16'h1);

      // Enable dropped with A held: no strobe; re-enable needs fresh A
      drive(1'b0, 14'h0000, 1'b0);
      bus.enable_i = 1'b0;
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("en_drop_no_strobe", 16'(bus.data_a_en_o), 16'h0);
      chk("en_drop_idle", 16'(bus.fsm_state_o), 16'h0);
      bus.enable_i = 1'b1;
      drive(1'b0, 14'h0000, 1'b0);
      chk("reen_no_strobe1", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b1, 14'h1FFF, 1'b1);
      chk("reen_no_strobe2", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b0, 14'h0000, 1'b0);
      chk("reen_no_strobe3", 16'(bus.data_a_en_o), 16'h0);
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("reen_strobe", 16'(bus.data_a_en_o), 16'h1);
      chk("reen_ovr_a", 16'(bus.ovr_a_o), 16'h1);
      chk("reen_locked", 16'(bus.locked_o), 16'h0);

      // Reset mid-pair overrides a pending emit
      drive(1'b0, 14'h0000, 1'b0);
      rst = 1'b1;
      drive(1'b1, 14'h1FFF, 1'b0);
      chk("mrst_en", 16'(bus.data_a_en_o), 16'h0);
      chk("mrst_data_a", 16'(bus.data_a_o), 16'h0000);
      chk("mrst_data_b", 16'(bus.data_b_o), 16'h0000);
      chk("mrst_ovr_a", 16'(bus.ovr_a_o), 16'h0);
      chk("mrst_ovr_b", 16'(bus.ovr_b_o), 16'h0);
      chk("mrst_errcnt", bus.sync_err_cnt_o, 16'h0000);
      chk("mrst_state", 16'(bus.fsm_state_o), 16'h0);
      rst = 1'b0;

      // Repeated A forever: error count increments then saturates
      drive(1'b1, 14'h1FFF, 1'b0);
      drive(1'b1, 14'h1FFF, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 14'h1FFF, 1'b0);
      chk("sat_err_pulse", 16'(bus.sync_err_o), 16'h1);
      chk("sat_cnt10", bus.sync_err_cnt_o, 16'd10);
      for (int i = 0; i < 70000; i++) drive(1'b1, 14'h1FFF, 1'b0);
      chk("sat_cnt_max", bus.sync_err_cnt_o, 16'hFFFF);
      chk("sat_locked", 16'(bus.locked_o), 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ad_mux_adc_rx.md
# ad_mux_adc_rx

- Receive-side interface for a dual-channel ADC that multiplexes both channels on one parallel bus, sample by sample.
- Sits between the ADC pins (after the pad/input registers) and the processing chain.
- Demultiplexes A/B samples into time-aligned pairs, converts ADC offset-binary (inverted-LSB) coding to signed two's complement, tracks channel alignment and overrange, and emits one paired sample per valid A/B sequence.
- Counterpart of the dual-channel DAC output driver: same 14-bit coding and same `data_x`/`data_x_en` stream convention.

## Interface
Parameters:
- DATA_WIDTH, 14, ADC sample width
- LOCK_PAIRS, 4, consecutive good pairs required before locked_o asserts (1..255)

Ports:
- adc_clk_i  in  1  ADC data clock; sole clock, all logic on rising edge
- adc_rst_i  in  1  reset; synchronous, active-high
- adc_dat_i  in  DATA_WIDTH  multiplexed ADC data, offset-binary inverted coding
- adc_sel_i  in  1  channel tag for adc_dat_i: 1 = channel A, 0 = channel B
- adc_ovr_i  in  1  ADC overrange flag for the sample on adc_dat_i
- enable_i  in  1  capture enable
- ovr_clr_i  in  1  one-cycle pulse; clears sticky overrange flags
- data_a_o  out  DATA_WIDTH  channel A sample, signed
- data_a_en_o  out  1  channel A valid strobe
- data_b_o  out  DATA_WIDTH  channel B sample, signed
- data_b_en_o  out  1  channel B valid strobe; always identical to data_a_en_o
- ovr_a_o  out  1  sticky channel A overrange
- ovr_b_o  out  1  sticky channel B overrange
- locked_o  out  1  alignment established
- sync_err_o  out  1  one-cycle pulse per alignment error
- sync_err_cnt_o  out  16  saturating alignment-error count

## Operation
Input stage:
- adc_dat_i, adc_sel_i, adc_ovr_i are registered once (stage S1) before use.

Conversion (bitwise, width-independent):
- signed = {raw[MSB], ~raw[MSB-1:0]}.
- Examples: 0x1FFF→0, 0x0000→+8191, 0x3FFF→−8192, 0x2000→−1.

FSM states and transitions:
- IDLE: entered on reset or whenever enable_i=0. Discards any held A. locked_o=0. Moves to HUNT when enable_i=1.
- HUNT: waits for S1 sel=1. On sel=1, holds the converted A sample and its ovr bit, then moves to GOT_A. sel=0 in HUNT is not an error.
- GOT_A:
  - S1 sel=0: emits the pair (held A, current B), strobes data_a_en_o and data_b_en_o, moves to EXP_A.
  - S1 sel=1 (A repeated): alignment error. Replaces held A with the new A and stays in GOT_A.
- EXP_A:
  - S1 sel=1: holds A, moves to GOT_A.
  - S1 sel=0 (B repeated): alignment error, moves to HUNT.

Lock tracking:
- A good-pair counter increments on each emitted pair, saturating at LOCK_PAIRS.
- locked_o=1 while the counter equals LOCK_PAIRS.
- Any alignment error, or entry to IDLE/HUNT from IDLE, clears the counter and locked_o in the same edge.

Alignment errors:
- Each error pulses sync_err_o for one cycle.
- Each error increments sync_err_cnt_o, which saturates at 0xFFFF and is cleared only by reset.

Sticky overrange:
- ovr_a_o/ovr_b_o set when an emitted pair contains an A/B sample whose ovr bit was 1.
- ovr_clr_i clears both flags.
- Set and clear in the same cycle: set wins.

Output data:
- data_a_o/data_b_o update only on an emit and hold otherwise.
- Pairs are never emitted with a missing or stale A.

## Timing
- Reset values: every output is 0, FSM in IDLE, held-A and counters cleared.
- Latency: A sampled at pins on edge E0 and B on E1 ⇒ pair outputs and strobes registered on E2, valid for the cycle after E2.
- Strobes are high for exactly one cycle per pair; maximum rate is one pair per 2 cycles.
- enable_i falling at any point, including with A held: no strobe on the following edges and the held A is discarded.
- On re-enable, the first pair needs a fresh A.
- Reset asserted mid-pair overrides everything on that edge.
- sync_err_o is registered, asserted the edge after the offending sample leaves S1, in the same edge as the FSM transition.

## Test plan
- Alternating sel 1,0,… with enable_i=1, A raw=0x1FFF, B raw=0x0000:
  - every 2 cycles a strobe with data_a_o=0x0000, data_b_o=0x1FFF;
  - locked_o rises on the edge of the 4th strobe;
  - sync_err_cnt_o=0.
- Coding sweep A raw 0x3FFF, B raw 0x2000 → data_a_o=0x2000 (−8192), data_b_o=0x3FFF (−1).
- Sel sequence 1,1,0 from lock:
  - one sync_err_o pulse and locked_o drops;
  - the emitted pair uses the second A;
  - sync_err_cnt_o=1.
- Sel sequence 0,0 in EXP_A → error pulse, return to HUNT, no strobe until the next A,B.
- adc_ovr_i=1 on one B sample → ovr_b_o=1 on that pair's emit edge and stays high; ovr_clr_i pulse clears it; ovr_clr_i coincident with a new overrange emit keeps it at 1.
- enable_i dropped between A and B → no strobe. adc_rst_i mid-stream → all outputs 0 on the next edge, counter 0. Force 70000 errors → sync_err_cnt_o holds 0xFFFF.
